// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, state and select encodings for the multicycle MIPS control unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_ADDR,
    S_BRANCH,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_MEM,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_b_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_t;

  // Successor of DECODE; anything outside the supported subset lands in TRAP.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_TRAP;
    if (op == OP_RTYPE && (fn == FN_ADD || fn == FN_SUB)) nxt = S_EXEC_R;
    else if (op == OP_LW || op == OP_SW)                  nxt = S_ADDR;
    else if (op == OP_BEQ || op == OP_BNE)                nxt = S_BRANCH;
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multicycle controller (master) and the shared datapath/memory (slave).
interface mips_mc_ctrl_if;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;

  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_we, reg_dst, mem_to_reg, fault, fault_code, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_we, reg_dst, mem_to_reg, fault, fault_code, retired
  );

endinterface

// File: rtl/mips_mc_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags a timeout once the allowance is used up.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_cyc,
  input  logic clr,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // A ready on the limit cycle drops wait_cyc, so it beats the timeout.
  assign timeout = wait_cyc && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (clr || !wait_cyc) cnt_q <= '0;
    else                      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore-decoded datapath controls, memory handshake, fault and retire tracking.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  state_t      state_q, state_d;
  fault_code_t fc_q, trap_code;
  logic        fault_q;
  logic [31:0] retired_q;
  logic        retire;
  logic        timeout;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wait_cyc (bus.mem_req && !bus.mem_ready),
    .clr      (state_d != state_q),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    trap_code      = FC_NONE;
    retire         = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_ADD;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d   = S_TRAP;
          trap_code = FC_TIMEOUT;
        end
      end

      // Branch target is precomputed into ALUOut here.
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        state_d       = decode_next(bus.opcode, bus.funct);
        if (state_d == S_TRAP) trap_code = FC_ILLEGAL;
      end

      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        state_d       = S_WB_R;
      end

      S_WB_R: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
        else if (timeout) begin
          state_d   = S_TRAP;
          trap_code = FC_TIMEOUT;
        end
      end

      S_WB_MEM: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
          trap_code = FC_TIMEOUT;
        end
      end

      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 1'b1;
        bus.pc_we     = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                        ((bus.opcode == OP_BNE) && !bus.zero);
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
      fc_q    <= FC_NONE;
    end else if (!fault_q && trap_code != FC_NONE) begin
      fault_q <= 1'b1;
      fc_q    <= trap_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign bus.fault      = fault_q;
  assign bus.fault_code = fc_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven bench for mips_mc_ctrl with a wait-state memory responder.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  int fetch_waits = 0;
  int data_waits  = 0;

  // Memory responder: each access sees the configured number of wait cycles, then one ready cycle.
  int   rsp_cnt  = 0;
  logic req_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst || !bus.mem_req) begin
      rsp_cnt       = 0;
      bus.mem_ready = 1'b0;
    end else begin
      if (bus.mem_ready || !req_prev) rsp_cnt = 0;
      else                            rsp_cnt++;
      bus.mem_ready = (rsp_cnt >= (bus.iord ? data_waits : fetch_waits));
    end
    req_prev = bus.mem_req;
  end

  function automatic logic [13:0] word();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_we, bus.reg_dst,
            bus.mem_to_reg};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Starts at the negedge of an instruction's first FETCH cycle and stops at the
  // negedge of the first cycle after it retires or traps.
  task automatic run_instr(output int cyc, output logic [13:0] last_w, output logic [13:0] end_w,
                           output int pcwe, output int runmax, output logic timed_out);
    logic [31:0] r0;
    int run;
    r0 = bus.retired;
    run = 0; cyc = 0; pcwe = 0; runmax = 0; timed_out = 1'b0; last_w = '0;
    while (bus.retired == r0 && !bus.fault) begin
      last_w = word();
      if (bus.pc_we) pcwe++;
      if (bus.mem_req && bus.iord) begin
        run++;
        if (run > runmax) runmax = run;
      end else run = 0;
      cyc++;
      if (cyc > 80) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    end_w = word();
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    int          fw;
    int          dw;
    int          cyc;
    logic [13:0] last_w;
    logic [13:0] end_w;
    int          ret;
    logic [1:0]  fc;
    int          pcwe;
    int          run;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int          cyc, pcwe, runmax;
    logic [13:0] last_w, end_w;
    logic        tmo;
    int          bad_req, bad_ret, bad_flt;

    vecs[0]  = '{"add_zw",      6'h00, 6'h20, 1'b0,  0,  0,  4, 14'h0006, 14'h2620, 1, 2'd0, 1,  0};
    vecs[1]  = '{"sub_fw2",     6'h00, 6'h22, 1'b0,  2,  0,  6, 14'h0006, 14'h2020, 1, 2'd0, 1,  0};
    vecs[2]  = '{"lw_dw3",      6'h23, 6'h00, 1'b0,  0,  3,  8, 14'h0005, 14'h2620, 1, 2'd0, 1,  4};
    vecs[3]  = '{"lw_zw",       6'h23, 6'h11, 1'b0,  0,  0,  5, 14'h0005, 14'h2620, 1, 2'd0, 1,  1};
    vecs[4]  = '{"sw_zw",       6'h2B, 6'h00, 1'b0,  0,  0,  4, 14'h3800, 14'h2620, 1, 2'd0, 1,  1};
    vecs[5]  = '{"sw_dw2",      6'h2B, 6'h00, 1'b0,  0,  2,  6, 14'h3800, 14'h2620, 1, 2'd0, 1,  3};
    vecs[6]  = '{"beq_z1",      6'h04, 6'h00, 1'b1,  0,  0,  3, 14'h0388, 14'h2620, 1, 2'd0, 2,  0};
    vecs[7]  = '{"beq_z0",      6'h04, 6'h00, 1'b0,  0,  0,  3, 14'h0188, 14'h2620, 1, 2'd0, 1,  0};
    vecs[8]  = '{"bne_z1",      6'h05, 6'h00, 1'b1,  0,  0,  3, 14'h0188, 14'h2620, 1, 2'd0, 1,  0};
    vecs[9]  = '{"bne_z0",      6'h05, 6'h00, 1'b0,  0,  0,  3, 14'h0388, 14'h2620, 1, 2'd0, 2,  0};
    vecs[10] = '{"ill_op3f",    6'h3F, 6'h20, 1'b0,  0,  0,  2, 14'h0060, 14'h0000, 0, 2'd1, 1,  0};
    vecs[11] = '{"ill_fn24",    6'h00, 6'h24, 1'b0,  0,  0,  2, 14'h0060, 14'h0000, 0, 2'd1, 1,  0};
    vecs[12] = '{"fetch_tmo",   6'h00, 6'h20, 1'b0, 16,  0, 16, 14'h2020, 14'h0000, 0, 2'd2, 0,  0};
    vecs[13] = '{"fetch_limit", 6'h00, 6'h20, 1'b0, 15,  0, 19, 14'h0006, 14'h2020, 1, 2'd0, 1,  0};
    vecs[14] = '{"lw_tmo",      6'h23, 6'h00, 1'b0,  0, 16, 19, 14'h2800, 14'h0000, 0, 2'd2, 1, 16};
    vecs[15] = '{"sw_limit",    6'h2B, 6'h00, 1'b0,  0, 15, 19, 14'h3800, 14'h2620, 1, 2'd0, 1, 16};

    bus.opcode = 6'h00;
    bus.funct  = 6'h20;
    bus.zero   = 1'b0;

    // Reset state
    #2;
    chk("rst_outputs", 32'(word()), 32'h0);
    chk("rst_retired", bus.retired, 32'h0);
    chk("rst_fault",   32'({bus.fault, bus.fault_code}), 32'h0);

    for (int i = 0; i < 16; i++) begin
      bus.opcode  = vecs[i].op;
      bus.funct   = vecs[i].fn;
      bus.zero    = vecs[i].zero;
      fetch_waits = vecs[i].fw;
      data_waits  = vecs[i].dw;
      apply_reset();
      chk({vecs[i].name, "_idle"}, 32'({word(), bus.mem_ready & bus.mem_req}), 32'h0);
      @(negedge clk);
      run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
      chk({vecs[i].name, "_bound"},   32'(tmo),             32'h0);
      chk({vecs[i].name, "_cycles"},  32'(cyc),             32'(vecs[i].cyc));
      chk({vecs[i].name, "_last"},    32'(last_w),          32'(vecs[i].last_w));
      chk({vecs[i].name, "_next"},    32'(end_w),           32'(vecs[i].end_w));
      chk({vecs[i].name, "_retired"}, bus.retired,          32'(vecs[i].ret));
      chk({vecs[i].name, "_fault"},   32'(bus.fault),       32'(vecs[i].fc != 2'd0));
      chk({vecs[i].name, "_fcode"},   32'(bus.fault_code),  32'(vecs[i].fc));
      chk({vecs[i].name, "_pcwe"},    32'(pcwe),            32'(vecs[i].pcwe));
      chk({vecs[i].name, "_memhold"}, 32'(runmax),          32'(vecs[i].run));
    end

    // Back-to-back: add, lw (1 wait), beq taken, sw
    fetch_waits = 0;
    data_waits  = 1;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b1;
    apply_reset();
    @(negedge clk);
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    chk("seq_add_cycles", 32'(cyc), 32'd4);
    bus.opcode = 6'h23;
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    chk("seq_lw_cycles", 32'(cyc), 32'd6);
    bus.opcode = 6'h04;
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    chk("seq_beq_cycles", 32'(cyc), 32'd3);
    chk("seq_beq_last",   32'(last_w), 32'h388);
    bus.opcode = 6'h2B;
    data_waits = 0;
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    chk("seq_sw_cycles", 32'(cyc), 32'd4);
    chk("seq_retired",   bus.retired, 32'd4);

    // Illegal opcode after a retired add: TRAP absorbs, memory stays idle, count frozen
    bus.opcode = 6'h00; bus.funct = 6'h20;
    apply_reset();
    @(negedge clk);
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    bus.opcode = 6'h3F;
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    chk("trap_cycles", 32'(cyc), 32'd2);
    bad_req = 0; bad_ret = 0; bad_flt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (word() != 14'h0)                           bad_req++;
      if (bus.retired != 32'd1)                      bad_ret++;
      if (!bus.fault || bus.fault_code != 2'b01)     bad_flt++;
    end
    chk("trap_outputs_idle",   32'(bad_req), 32'd0);
    chk("trap_retired_frozen", 32'(bad_ret), 32'd0);
    chk("trap_fault_sticky",   32'(bad_flt), 32'd0);

    // Asynchronous reset while MEM_WR is stalled
    bus.opcode = 6'h00; bus.funct = 6'h20;
    fetch_waits = 0; data_waits = 10;
    apply_reset();
    @(negedge clk);
    run_instr(cyc, last_w, end_w, pcwe, runmax, tmo);
    bus.opcode = 6'h2B;
    repeat (3) @(negedge clk);
    chk("midwr_in_memwr",  32'(word()), 32'h3800);
    chk("midwr_pre_count", bus.retired, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midwr_rst_outputs", 32'(word()), 32'h0);
    chk("midwr_rst_retired", bus.retired, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midwr_restart_idle", 32'(word()), 32'h0);
    @(negedge clk);
    chk("midwr_restart_fetch", 32'(word()), 32'h2620);
    chk("midwr_restart_count", bus.retired, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control unit for the MIPS core. It sequences one shared datapath (PC, IR, register file, ALU, single memory port) through fetch, decode, execute, memory and writeback. It waits on a memory ready handshake and flags illegal opcodes and memory timeouts. It supports add, sub, lw, sw, beq and bne, and sits between the instruction register and every datapath enable and mux select.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum number of consecutive wait cycles on `mem_ready` before a fault.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0. Valid in the BRANCH state.
- `mem_ready` in 1: memory has completed the current access. Sampled only while `mem_req`=1.
- `mem_req` out 1: memory access active.
- `mem_we` out 1: memory access is a write.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_we` out 1: load IR.
- `pc_we` out 1: load PC.
- `pc_src` out 1: PC source. 0 = ALU result, 1 = ALUOut.
- `alu_src_a` out 1: ALU A source. 0 = PC, 1 = reg A.
- `alu_src_b` out 2: ALU B source. 00 = reg B, 01 = const 4, 10 = sign_ext_imm, 11 = sign_ext_imm<<2.
- `alu_op` out 2: ALU operation. 00 = add, 01 = sub, 10 = decode funct.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback data. 0 = ALUOut, 1 = MDR.
- `fault` out 1: sticky fault. Cleared only by reset.
- `fault_code` out 2: 00 = none, 01 = illegal opcode/funct, 10 = memory timeout.
- `retired` out 32: count of completed instructions. Wraps 0xFFFFFFFF → 0.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC_R, ADDR, BRANCH, MEM_RD, MEM_WR, WB_R, WB_MEM, TRAP.
- **Outputs** are Moore-decoded from state. Any output not listed for a state is 0.
- **IDLE:** no outputs. → FETCH unconditionally.
- **FETCH:**
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_we`=`pc_we`=`mem_ready`, so PC+4 and IR are loaded on the ready edge.
  - → DECODE on `mem_ready`, otherwise stay.
- **DECODE:**
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target goes to ALUOut).
  - Next state by opcode:
    - 0x00 with funct 0x20 or 0x22 → EXEC_R.
    - 0x23 or 0x2B → ADDR.
    - 0x04 or 0x05 → BRANCH.
    - Anything else → TRAP with code 01.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. → WB_R.
- **WB_R:** `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Retire. → FETCH.
- **ADDR:** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. → MEM_RD (0x23) or MEM_WR (0x2B).
- **MEM_RD:** `mem_req`=1, `iord`=1. → WB_MEM on `mem_ready`.
- **WB_MEM:** `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Retire. → FETCH.
- **MEM_WR:** `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready`: retire, → FETCH.
- **BRANCH:**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=1.
  - `pc_we` = (beq & `zero`) | (bne & !`zero`).
  - Retire. → FETCH.
- **TRAP:** all outputs 0 except `fault`/`fault_code`/`retired`. Absorbing state.
- **Wait counter:**
  - Counts consecutive cycles with `mem_req`=1 and `mem_ready`=0. Clears on `mem_ready` and on every state change.
  - When the count reaches `TIMEOUT_CYCLES` and `mem_ready` is still 0 → TRAP with code 10.
  - `mem_ready` arriving on the same edge as the limit wins: no fault.
- **Retire:** `retired` increments on the clock edge leaving WB_R, WB_MEM, BRANCH, or MEM_WR-with-ready.

## Timing
- **Reset:** state=IDLE, `retired`=0, `fault`=0, `fault_code`=00. Every output is 0 while `rst`=1.
- **Asynchronous reset mid-operation:** immediate return to IDLE. No partial write is completed.
- **First cycle after reset release:** IDLE. `mem_req` rises one cycle later.
- **Latency with zero-wait memory** (`mem_ready`=1 on first sample):

| Instruction | Cycles |
|---|---|
| R-type | 4 |
| lw | 5 |
| sw | 4 |
| beq/bne | 3 |

  Each memory wait cycle adds one cycle.
- **Hold rule:** `mem_req`, `mem_we` and `iord` stay stable until the ready edge. `mem_ready` outside a memory state is ignored.

## Structure
- Package `mips_pkg` holds:
  - Opcode constants: OP_RTYPE=0x00, OP_LW=0x23, OP_SW=0x2B, OP_BEQ=0x04, OP_BNE=0x05.
  - Funct constants: FN_ADD=0x20, FN_SUB=0x22.
  - Enums for state, ALU-op, ALU-B select and fault_code.
- One sub-module, `mem_wait_timer`: the wait counter plus timeout compare, parameterised by `TIMEOUT_CYCLES`.
- Next-state logic and output decode stay in `mips_mc_ctrl`.

## Test plan
- **add, zero-wait:** reset, then opcode=0x00/funct=0x20 with `mem_ready`=1.
  - States IDLE→FETCH→DECODE→EXEC_R→WB_R.
  - `reg_we`=1 and `reg_dst`=1 in WB_R only; `retired`=1 after 4 cycles past IDLE.
- **lw with 3 wait cycles in MEM_RD:** `mem_req`=1 and `iord`=1 are held for 4 cycles; WB_MEM asserts `mem_to_reg`=1; total 8 cycles.
- **beq/bne, both `zero` values:**
  - beq with `zero`=1 → `pc_we`=1 and `pc_src`=1 in BRANCH.
  - beq with `zero`=0 → `pc_we`=0.
  - bne shows the inverse.
- **Illegal input:** opcode=0x3F → TRAP, `fault`=1, `fault_code`=01, `retired` frozen, `mem_req` stays 0 for 20 cycles. Repeat with opcode 0x00/funct=0x24: same result.
- **Timeout boundary with `TIMEOUT_CYCLES`=15:**
  - `mem_ready` held 0 in FETCH → TRAP with `fault_code`=10.
  - `mem_ready`=1 on the limit cycle → no fault.
- **Reset mid-MEM_WR:** assert `rst` → all outputs 0 immediately; after release the sequence restarts at IDLE with `retired`=0.
